// File: rtl/word_fill_sequencer.sv
// Cache-block refill word sequencer: steps a one-hot word select through a block
// as memory beats arrive. Define WFS_CRIT_FIRST_EN for critical-word-first order.
module word_fill_sequencer #(
    parameter int OFFSET_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OFFSET_W-1:0]      offset,
    input  logic                     fill_req,
    input  logic                     mem_valid,
    input  logic                     abort,
    output logic [(2**OFFSET_W)-1:0] word_en,
    output logic                     fill_we,
    output logic                     crit_word,
    output logic                     busy,
    output logic                     fill_done
);

    localparam int WORDS = 2 ** OFFSET_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [OFFSET_W-1:0]   ptr_reg, ptr_next;
    logic [OFFSET_W-1:0]   count_reg, count_next;
    logic [OFFSET_W-1:0]   req_off_reg, req_off_next;
    logic [OFFSET_W-1:0]   start_ptr;
    logic [WORDS-1:0]      offset_dec;
    logic [WORDS-1:0]      ptr_dec;
    logic                  beat;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_dec
            assign offset_dec[gi] = (offset == OFFSET_W'(gi));
            assign ptr_dec[gi]    = (ptr_reg == OFFSET_W'(gi));
        end
    endgenerate

`ifdef WFS_CRIT_FIRST_EN
    // Critical-word-first: the requested word arrives on the first beat.
    assign start_ptr = offset;
`else
    assign start_ptr = '0;
`endif

    // Abort wins over a same-cycle memory beat, so no write happens.
    assign beat = (state_reg == FILL) && mem_valid && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            count_reg   <= '0;
            req_off_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            count_reg   <= count_next;
            req_off_reg <= req_off_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        count_next   = count_reg;
        req_off_next = req_off_reg;
        case (state_reg)
            IDLE: begin
                if (fill_req) begin
                    state_next   = FILL;
                    req_off_next = offset;
                    ptr_next     = start_ptr;
                    count_next   = '0;
                end
            end
            FILL: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (mem_valid) begin
                    ptr_next   = ptr_reg + 1'b1;
                    count_next = count_reg + 1'b1;
                    if (count_reg == OFFSET_W'(WORDS - 1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        word_en   = '0;
        fill_we   = beat;
        crit_word = beat && (ptr_reg == req_off_reg);
        busy      = (state_reg != IDLE);
        fill_done = (state_reg == DONE);
        case (state_reg)
            IDLE:    word_en = offset_dec;
            FILL:    word_en = ptr_dec;
            default: word_en = '0;
        endcase
    end

endmodule

// File: tb/tb_word_fill_sequencer.sv
// Directed bench for word_fill_sequencer (OFFSET_W=3); follows WFS_CRIT_FIRST_EN
// if the build defines it.
module tb_word_fill_sequencer;

    logic       clk;
    logic       rst_n;
    logic [2:0] offset;
    logic       fill_req;
    logic       mem_valid;
    logic       abort;
    logic [7:0] word_en;
    logic       fill_we;
    logic       crit_word;
    logic       busy;
    logic       fill_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] seen [8];

    word_fill_sequencer #(.OFFSET_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .offset    (offset),
        .fill_req  (fill_req),
        .mem_valid (mem_valid),
        .abort     (abort),
        .word_en   (word_en),
        .fill_we   (fill_we),
        .crit_word (crit_word),
        .busy      (busy),
        .fill_done (fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] start_of(input logic [2:0] o);
`ifdef WFS_CRIT_FIRST_EN
        return o;
`else
        return 3'd0;
`endif
    endfunction

    // Full refill with a beat every cycle; records the word selects seen.
    task automatic run_fill(input logic [2:0] o);
        logic [2:0] p;
        offset    = o;
        fill_req  = 1'b1;
        mem_valid = 1'b0;
        #1;
        chk("req_idle_busy", busy, 1'b0);
        tick();
        fill_req  = 1'b0;
        mem_valid = 1'b1;
        for (int b = 0; b < 8; b++) begin
            #1;
            p = 3'(start_of(o) + 3'(b));
            chk("fill_word_en", word_en, 8'h01 << p);
            chk("fill_we", fill_we, 1'b1);
            chk("fill_crit", crit_word, (p == o));
            chk("fill_busy", busy, 1'b1);
            chk("fill_no_done", fill_done, 1'b0);
            seen[b] = word_en;
            tick();
        end
        #1;
        chk("done_pulse", fill_done, 1'b1);
        chk("done_word_en", word_en, 8'h00);
        chk("done_we", fill_we, 1'b0);
        chk("done_busy", busy, 1'b1);
        mem_valid = 1'b0;
        tick();
        chk("post_done", fill_done, 1'b0);
        chk("post_busy", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] tbl [8];
        int         writes;
        bit         done_seen;
        bit         mv;

        rst_n     = 1'b0;
        offset    = 3'd5;
        fill_req  = 1'b0;
        mem_valid = 1'b0;
        abort     = 1'b0;

        // Reset state
        #1;
        chk("rst_word_en5", word_en, 8'h20);
        chk("rst_busy", busy, 1'b0);
        chk("rst_we", fill_we, 1'b0);
        chk("rst_done", fill_done, 1'b0);
        offset = 3'd0;
        #1;
        chk("rst_word_en0", word_en, 8'h01);
        #20;
        rst_n = 1'b1;
        tick();

        // IDLE decode
        offset = 3'd5;
        #1;
        chk("idle_word_en5", word_en, 8'h20);
        chk("idle_we", fill_we, 1'b0);
        chk("idle_busy", busy, 1'b0);
        offset = 3'd0;
        #1;
        chk("idle_word_en0", word_en, 8'h01);
        tick();

        // Continuous refill, offset 6, against the hand table
        run_fill(3'd6);
`ifdef WFS_CRIT_FIRST_EN
        tbl = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
`else
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`endif
        for (int b = 0; b < 8; b++) chk("table_word_en", seen[b], tbl[b]);

        // Gapped refill, pattern 1,0,0,1
        offset   = 3'd2;
        fill_req = 1'b1;
        tick();
        fill_req  = 1'b0;
        writes    = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            mv = ((c % 4) == 0) || ((c % 4) == 3);
            mem_valid = mv;
            #1;
            if (fill_done) begin
                done_seen = 1'b1;
                break;
            end
            chk("gap_word_en", word_en, 8'h01 << 3'(start_of(3'd2) + 3'(writes)));
            chk("gap_we", fill_we, mv);
            if (mv) writes++;
            tick();
        end
        chk("gap_done_seen", done_seen, 1'b1);
        chk("gap_writes", writes, 8);
        mem_valid = 1'b0;
        tick();
        chk("gap_idle", busy, 1'b0);

        // Abort on beat 3 with a simultaneous memory beat
        offset   = 3'd1;
        fill_req = 1'b1;
        tick();
        fill_req  = 1'b0;
        mem_valid = 1'b1;
        #1;
        chk("abort_beat1_we", fill_we, 1'b1);
        tick();
        tick();
        abort = 1'b1;
        #1;
        chk("abort_we", fill_we, 1'b0);
        chk("abort_crit", crit_word, 1'b0);
        chk("abort_busy", busy, 1'b1);
        tick();
        abort     = 1'b0;
        mem_valid = 1'b0;
        chk("abort_idle", busy, 1'b0);
        chk("abort_no_done", fill_done, 1'b0);
        tick();
        chk("abort_no_done2", fill_done, 1'b0);
        run_fill(3'd1);

        // Reset during beat 4
        offset   = 3'd3;
        fill_req = 1'b1;
        tick();
        fill_req  = 1'b0;
        mem_valid = 1'b1;
        tick();
        tick();
        tick();
        #2;
        chk("pre_rst_we", fill_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_we", fill_we, 1'b0);
        chk("midrst_word_en", word_en, 8'h08);
        chk("midrst_done", fill_done, 1'b0);
        tick();
        tick();
        chk("midrst_done2", fill_done, 1'b0);
        rst_n     = 1'b1;
        mem_valid = 1'b0;
        tick();
        chk("post_rst_done", fill_done, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        run_fill(3'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
